// File: rtl/pc_unit.sv
// Fetch program counter with sequential/branch/jalr/return next-PC selection.
// Optional return-address stack is built when PC_RAS_EN is defined.
module pc_unit #(
  parameter int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            call,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_add4,
  output logic [XLEN-1:0] pc_imm,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  logic [XLEN-1:0] jalr_tgt;
  logic            advance;

  assign pc_add4  = pc + XLEN'(4);
  assign pc_imm   = pc + imm;
  assign jalr_tgt = (rs1 + imm) & ~XLEN'(1);

`ifdef PC_RAS_EN
  localparam int unsigned AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [AW-1:0]   top;
  logic [AW:0]     cnt;
  logic            ras_hit;
  logic            push;
  logic            pop;

  assign ras_hit   = (cnt != '0);
  assign push      = advance && call;
  assign pop       = advance && (sel == 2'b11) && ras_hit;
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == (AW+1)'(RAS_DEPTH));

  always_comb begin
    next_pc = pc_add4;
    case (sel)
      2'b00:   next_pc = pc_add4;
      2'b01:   next_pc = pc_imm;
      2'b10:   next_pc = jalr_tgt;
      default: next_pc = ras_hit ? ras_mem[top] : jalr_tgt;
    endcase
  end

  // Top pointer and occupancy; a full stack keeps wrapping over its oldest entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      top <= top + AW'(1);
      if (cnt != (AW+1)'(RAS_DEPTH)) cnt <= cnt + (AW+1)'(1);
    end else if (pop && !push) begin
      top <= top - AW'(1);
      cnt <= cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && pop)  ras_mem[top]          <= pc_add4;
    else if (push)    ras_mem[top + AW'(1)] <= pc_add4;
  end
`else
  localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
  logic unused_call;

  assign unused_call = call;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;

  always_comb begin
    next_pc = pc_add4;
    case (sel)
      2'b00:   next_pc = pc_add4;
      2'b01:   next_pc = pc_imm;
      default: next_pc = jalr_tgt;
    endcase
  end
`endif

  assign misaligned = en && !redirect_valid && (next_pc[1:0] != 2'b00);
  assign advance    = en && !redirect_valid && !misaligned;

  // Redirect wins even during a stall; a misaligned target freezes the PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                pc <= RESET_VECTOR;
    else if (redirect_valid) pc <= redirect_pc;
    else if (advance)        pc <= next_pc;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; the RAS scenarios are selected by PC_RAS_EN.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  sel;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        call;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc, pc_add4, pc_imm, next_pc;
  logic        misaligned, ras_empty, ras_full;

  int checks = 0;
  int errors = 0;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .imm(imm), .rs1(rs1),
    .call(call), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .pc_add4(pc_add4), .pc_imm(pc_imm), .next_pc(next_pc),
    .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] pops [4];
    rst = 1'b0; en = 1'b0; sel = 2'b00; imm = '0; rs1 = '0; call = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    chk("reset_pc", pc, 32'h0);
    chk("reset_empty", 32'(ras_empty), 32'h1);
    chk("reset_full", 32'(ras_full), 32'h0);
    chk("reset_add4", pc_add4, 32'h4);
    rst = 1'b1; en = 1'b1;
    tick(); chk("seq_4", pc, 32'h4);
    tick(); chk("seq_8", pc, 32'h8);
    tick(); chk("seq_c", pc, 32'hC);
    tick(); chk("seq_10", pc, 32'h10);

    // stall and redirect
    en = 1'b0;
    tick(); chk("stall_hold", pc, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick(); chk("redirect_stalled", pc, 32'h200);
    redirect_valid = 1'b0;

    // branch, jalr, misalignment
    jump(32'h100);
    en = 1'b1; sel = 2'b01; imm = 32'hFFFF_FFF8;
    #1 chk("branch_pc_imm", pc_imm, 32'hF8);
    tick(); chk("branch_back", pc, 32'hF8);
    sel = 2'b10; rs1 = 32'h301; imm = '0;
    #1 chk("jalr_next", next_pc, 32'h300);
    tick(); chk("jalr_pc", pc, 32'h300);
    sel = 2'b01; imm = 32'h2;
    #1 chk("misaligned_flag", 32'(misaligned), 32'h1);
    tick(); chk("misaligned_hold", pc, 32'h300);
    en = 1'b0;
    #1 chk("misaligned_stalled", 32'(misaligned), 32'h0);

`ifdef PC_RAS_EN
    // call then return
    jump(32'h40);
    en = 1'b1; call = 1'b1; sel = 2'b01; imm = 32'h100;
    tick(); chk("call_pc", pc, 32'h140);
    chk("call_nonempty", 32'(ras_empty), 32'h0);
    call = 1'b0; sel = 2'b11;
    #1 chk("ret_next", next_pc, 32'h44);
    tick(); chk("ret_pc", pc, 32'h44);
    chk("ret_empty", 32'(ras_empty), 32'h1);

    // five pushes into a four-deep stack: A1=0x48 .. A5=0x448
    call = 1'b1; sel = 2'b01; imm = 32'h100;
    for (int i = 0; i < 5; i++) tick();
    chk("ovf_pc", pc, 32'h544);
    chk("ovf_full", 32'(ras_full), 32'h1);
    call = 1'b0; sel = 2'b11; rs1 = 32'h80; imm = '0;
    pops[0] = 32'h448; pops[1] = 32'h348; pops[2] = 32'h248; pops[3] = 32'h148;
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("pop_%0d", i), pc, pops[i]);
    end
    chk("pops_empty", 32'(ras_empty), 32'h1);
    tick(); chk("empty_pop_fallback", pc, 32'h80);

    // push and pop in one cycle replaces the top
    jump(32'h0);
    call = 1'b1; sel = 2'b01; imm = 32'h20;
    tick(); chk("pp_call", pc, 32'h20);
    sel = 2'b11;
    tick(); chk("pp_swap_pc", pc, 32'h4);
    chk("pp_nonempty", 32'(ras_empty), 32'h0);
    call = 1'b0;
    tick(); chk("pp_ret", pc, 32'h24);
    chk("pp_empty", 32'(ras_empty), 32'h1);
`else
    // sel=11 without RAS is jalr; call is ignored
    en = 1'b1; call = 1'b1; sel = 2'b11; rs1 = 32'h81; imm = 32'h10;
    #1 chk("noras_next", next_pc, 32'h90);
    tick(); chk("noras_pc", pc, 32'h90);
    chk("noras_empty", 32'(ras_empty), 32'h1);
    chk("noras_full", 32'(ras_full), 32'h0);
    call = 1'b0;
`endif

    // wrap-around
    en = 1'b0;
    jump(32'hFFFF_FFFC);
    en = 1'b1; sel = 2'b00; call = 1'b1;
    #1 chk("wrap_add4", pc_add4, 32'h0);
    tick(); chk("wrap_pc", pc, 32'h0);
    tick(); chk("after_wrap", pc, 32'h4);
`ifdef PC_RAS_EN
    chk("wrap_pushed", 32'(ras_empty), 32'h0);
`endif

    // async reset between edges
    call = 1'b0; en = 1'b0;
    #1 rst = 1'b0;
    #1 chk("async_pc", pc, 32'h0);
    chk("async_empty", 32'(ras_empty), 32'h1);
    chk("async_full", 32'(ras_full), 32'h0);
    tick(); chk("reset_held", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
